mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Bus responder for the 16-bit multi-cycle CPU: serves every CPU bus cycle (fetch, load, store, push, pop, call, return) on the shared address/data/write bus.
- Decodes the 12-bit address into word RAM (0x000–0xEFF) and a memory-mapped I/O page (0xF00–0xFFF).
- The I/O page holds an LED register, a compare timer, and a transmit FIFO drained by an external consumer over a valid/ready handshake.

Parameters:
- RAM_WORDS, 3840, number of 16-bit RAM words mapped from 0x000.
- INIT_FILE, "", hex image loaded into RAM at elaboration; empty string means no load.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, maximum 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- address  input  12  word address driven by the CPU.
- data_in  input  16  write data from the CPU.
- mem_wrt  input  1  write strobe; the write commits at the rising edge while high.
- data_out  output  16  read data to the CPU.
- leds  output  16  LED register contents.
- timer_irq  output  1  copy of the timer match flag.
- tx_data  output  16  head entry of the TX FIFO.
- tx_valid  output  1  FIFO not empty.
- tx_ready  input  1  consumer accepts tx_data at the rising edge when tx_valid and tx_ready are both high.

Behaviour:
- Reads are combinational: data_out is a function of address and current state in the same cycle, with no wait states, so the CPU samples it at the closing edge.
- Writes are synchronous: the target changes at the rising edge where mem_wrt=1. Read-during-write returns the old value.
- RAM: 0x000 to RAM_WORDS-1. Not cleared by rst. Addresses from RAM_WORDS to 0xEFF read 0x0000 and ignore writes.
- 0xF00 LED: read/write; reset value 0x0000.
- 0xF01 TCOUNT: read/write; reset 0.
  - Increments by 1 per cycle while CTRL.en=1, wrapping 0xFFFF to 0x0000.
  - A CPU write to TCOUNT overrides the increment in that cycle.
- 0xF02 TCTRL:
  - bit0 en; bit1 autoclr; bit15 match (read-only via write; writing 1 clears it).
  - Other bits read 0. Reset value 0x0000.
- 0xF03 TCMP: read/write; reset 0xFFFF.
- Timer match:
  - Condition: en=1 and TCOUNT==TCMP at a rising edge.
  - Sets match=1. If autoclr=1, TCOUNT becomes 0 instead of incrementing.
  - If a match and a W1C of match occur in the same cycle, set wins.
  - timer_irq equals match.
- 0xF04 TXDATA:
  - A write pushes data_in. Reads return 0x0000.
  - The push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise data is dropped and sticky ovf is set.
- 0xF05 TXSTAT:
  - bit0 empty; bit1 full; bit2 ovf (writing 1 clears; set wins if simultaneous); bits[6:3] count (0..8).
  - Other bits read 0.
- 0xF06–0xFFF: read 0x0000; writes ignored.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - tx_data shows the head whenever tx_valid=1; tx_data is don't-care when empty.
  - Pop occurs when tx_valid and tx_ready are both high.
  - Push and pop in the same cycle leave count unchanged. Pop when empty never happens.
- Reset:
  - rst clears LED, TCOUNT, TCTRL, ovf, FIFO pointers and count, and sets TCMP to 0xFFFF.
  - Effective at the next rising edge regardless of mem_wrt. A write coincident with rst is discarded for I/O; RAM still accepts it.
  - Outputs after reset: leds=0, timer_irq=0, tx_valid=0.

Decomposition:
- Package mem_io_pkg holds:
  - address constants IO_BASE=0xF00, A_LED, A_TCOUNT, A_TCTRL, A_TCMP, A_TXDATA, A_TXSTAT;
  - TCTRL bit indices EN=0, AUTOCLR=1, MATCH=15;
  - TXSTAT bit indices.
- One sub-module, tx_fifo, parameterised by depth and width. It provides push/pop/full/empty/count/head. It applies the accept-on-simultaneous-pop rule internally and reports dropped pushes for ovf.
- Decode, RAM, LED and timer stay in the top level.

Test Plan:
- RAM write/read: write 0x1234 to 0x010, then place address 0x010 with mem_wrt=0 → data_out=0x1234 in the same cycle. Then write 0xFFFF to 0xF80 and read it back → 0x0000.
- LED and reset: write 0xA5A5 to 0xF00 → leds=0xA5A5 after the edge. Assert rst for 1 cycle → leds=0x0000 and RAM word 0x010 still reads 0x1234.
- Timer autoclear: TCMP=3, TCTRL=0x0003, TCOUNT=0 → TCOUNT reads 0,1,2,3,0 on successive cycles and timer_irq rises after the edge at count 3. Write 0x8003 to TCTRL → match clears while the timer keeps running.
- Timer wrap: TCOUNT=0xFFFE, en=1, autoclr=0, TCMP=0x0005 → reads 0xFFFE, 0xFFFF, 0x0000 with no match flag.
- FIFO fill/overflow: with tx_ready=0, push 9 words 0x0001..0x0009 → TXSTAT=0x0042 (count=8, full) after 8 pushes, then 0x0046 after the 9th (ovf set, 0x0009 dropped). Raise tx_ready → tx_data sequence 0x0001..0x0008, then empty=1.
- FIFO push+pop when full: FIFO full with tx_ready=1, push 0x00AA in the same cycle → count stays 8, ovf unchanged, and 0x00AA is popped last.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared address map, register bit positions and field packing for the
// CPU-side memory/I/O responder.
package mem_io_pkg;

  localparam logic [11:0] IO_BASE  = 12'hF00;
  localparam logic [11:0] A_LED    = 12'hF00;
  localparam logic [11:0] A_TCOUNT = 12'hF01;
  localparam logic [11:0] A_TCTRL  = 12'hF02;
  localparam logic [11:0] A_TCMP   = 12'hF03;
  localparam logic [11:0] A_TXDATA = 12'hF04;
  localparam logic [11:0] A_TXSTAT = 12'hF05;

  localparam int EN      = 0;
  localparam int AUTOCLR = 1;
  localparam int MATCH   = 15;

  localparam int TXS_EMPTY     = 0;
  localparam int TXS_FULL      = 1;
  localparam int TXS_OVF       = 2;
  localparam int TXS_COUNT_LSB = 3;
  localparam int TXS_COUNT_MSB = 6;

  localparam logic [15:0] TCMP_RESET = 16'hFFFF;

  typedef struct packed {
    logic match;
    logic autoclr;
    logic en;
  } tctrl_t;

  function automatic logic [15:0] pack_tctrl(input tctrl_t c);
    logic [15:0] r;
    r          = '0;
    r[EN]      = c.en;
    r[AUTOCLR] = c.autoclr;
    r[MATCH]   = c.match;
    return r;
  endfunction

  function automatic logic [15:0] pack_txstat(input logic empty, input logic full,
                                              input logic ovf, input logic [3:0] count);
    logic [15:0] r;
    r                                = '0;
    r[TXS_EMPTY]                     = empty;
    r[TXS_FULL]                      = full;
    r[TXS_OVF]                       = ovf;
    r[TXS_COUNT_MSB:TXS_COUNT_LSB]   = count;
    return r;
  endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// Circular TX FIFO; a push into a full FIFO is still accepted when a pop
// frees a slot in the same cycle, otherwise it is reported as dropped.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [3:0]       count,
  output logic             dropped
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             do_pop, do_push;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != DEPTH_C) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head    = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign dropped = push && !do_push;

endmodule

// File: rtl/mem_io_responder.sv
// Single-cycle bus responder: word RAM below 0xF00, an I/O page above it
// with LEDs, a compare timer and a TX FIFO. Reads are combinational.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    RAM_WORDS  = 3840,
  parameter string INIT_FILE  = "",
  parameter int    FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] address,
  input  logic [15:0] data_in,
  input  logic        mem_wrt,
  output logic [15:0] data_out,
  output logic [15:0] leds,
  output logic        timer_irq,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [15:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit;

  logic [15:0] led_q, led_d;
  logic [15:0] tcount_q, tcount_d;
  logic [15:0] tcmp_q, tcmp_d;
  tctrl_t      tctrl_q, tctrl_d;
  logic        ovf_q, ovf_d;
  logic        match_hit;

  logic        wr_led, wr_tcount, wr_tctrl, wr_tcmp, wr_txdata, wr_txstat;
  logic        fifo_empty, fifo_full, fifo_drop, fifo_pop;
  logic [3:0]  fifo_count;
  logic [15:0] fifo_head;

  assign ram_idx = address[RAM_AW-1:0];
  assign ram_hit = ({1'b0, address} < 13'(RAM_WORDS));

  // RAM ignores rst so a write issued during reset still lands.
  always_ff @(posedge clk) begin
    if (mem_wrt && ram_hit) ram[ram_idx] <= data_in;
  end

  assign wr_led    = mem_wrt && (address == A_LED);
  assign wr_tcount = mem_wrt && (address == A_TCOUNT);
  assign wr_tctrl  = mem_wrt && (address == A_TCTRL);
  assign wr_tcmp   = mem_wrt && (address == A_TCMP);
  assign wr_txdata = mem_wrt && (address == A_TXDATA);
  assign wr_txstat = mem_wrt && (address == A_TXSTAT);

  assign match_hit = tctrl_q.en && (tcount_q == tcmp_q);

  always_comb begin
    led_d    = wr_led  ? data_in : led_q;
    tcmp_d   = wr_tcmp ? data_in : tcmp_q;

    tcount_d = tcount_q;
    if (tctrl_q.en) tcount_d = (match_hit && tctrl_q.autoclr) ? 16'h0000 : tcount_q + 16'd1;
    if (wr_tcount)  tcount_d = data_in;

    // Match is W1C, but a same-cycle match sets it again.
    tctrl_d = tctrl_q;
    if (wr_tctrl) begin
      tctrl_d.en      = data_in[EN];
      tctrl_d.autoclr = data_in[AUTOCLR];
      if (data_in[MATCH]) tctrl_d.match = 1'b0;
    end
    if (match_hit) tctrl_d.match = 1'b1;

    ovf_d = ovf_q;
    if (wr_txstat && data_in[TXS_OVF]) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      tcount_q <= '0;
      tcmp_q   <= TCMP_RESET;
      tctrl_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      tctrl_q  <= tctrl_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fifo_pop = tx_valid && tx_ready;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_txdata && !rst),
    .din     (data_in),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count),
    .dropped (fifo_drop)
  );

  always_comb begin
    data_out = '0;
    if (address < IO_BASE) begin
      if (ram_hit) data_out = ram[ram_idx];
    end else begin
      case (address)
        A_LED:    data_out = led_q;
        A_TCOUNT: data_out = tcount_q;
        A_TCTRL:  data_out = pack_tctrl(tctrl_q);
        A_TCMP:   data_out = tcmp_q;
        A_TXSTAT: data_out = pack_txstat(fifo_empty, fifo_full, ovf_q, fifo_count);
        default:  data_out = '0;
      endcase
    end
  end

  assign leds      = led_q;
  assign timer_irq = tctrl_q.match;
  assign tx_data   = fifo_head;
  assign tx_valid  = !fifo_empty;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed scenarios plus a randomized run, all checked against a queue/array
// model of the memory map kept in this bench.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst, mem_wrt, tx_ready;
  logic [11:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out, leds, tx_data;
  logic        timer_irq, tx_valid;

  int total = 0;
  int bad   = 0;

  mem_io_responder #(.RAM_WORDS(3840), .INIT_FILE(""), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .data_in   (data_in),
    .mem_wrt   (mem_wrt),
    .data_out  (data_out),
    .leds      (leds),
    .timer_irq (timer_irq),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model of the visible state.
  logic [15:0] m_ram [4096];
  logic [15:0] m_led, m_tcount, m_tcmp;
  bit          m_en, m_autoclr, m_match, m_ovf;
  logic [15:0] m_q [$];

  function automatic logic [15:0] m_read(input logic [11:0] a);
    int n;
    n = m_q.size();
    if (a < 12'hF00) return m_ram[a];
    case (a)
      12'hF00: return m_led;
      12'hF01: return m_tcount;
      12'hF02: return {m_match, 13'b0, m_autoclr, m_en};
      12'hF03: return m_tcmp;
      12'hF05: return {9'b0, 4'(n), m_ovf, 1'(n == 8), 1'(n == 0)};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_step();
    int          n;
    bit          pop, hit;
    logic [15:0] nc;
    if (mem_wrt && address < 12'hF00) m_ram[address] = data_in;
    if (rst) begin
      m_led = 0; m_tcount = 0; m_tcmp = 16'hFFFF;
      m_en = 0; m_autoclr = 0; m_match = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    n   = m_q.size();
    pop = tx_ready && (n > 0);
    hit = m_en && (m_tcount == m_tcmp);
    nc  = m_tcount;
    if (m_en) nc = (hit && m_autoclr) ? 16'h0000 : m_tcount + 16'd1;
    if (mem_wrt && address == 12'hF01) nc = data_in;
    if (mem_wrt && address == 12'hF02) begin
      m_en = data_in[0];
      m_autoclr = data_in[1];
      if (data_in[15]) m_match = 0;
    end
    if (hit) m_match = 1;
    m_tcount = nc;
    if (mem_wrt && address == 12'hF00) m_led = data_in;
    if (mem_wrt && address == 12'hF03) m_tcmp = data_in;
    if (mem_wrt && address == 12'hF05 && data_in[2]) m_ovf = 0;
    if (pop) void'(m_q.pop_front());
    if (mem_wrt && address == 12'hF04) begin
      if (n < 8 || pop) m_q.push_back(data_in);
      else m_ovf = 1;
    end
  endtask

  // Advance one clock edge; inputs change 1 time unit after the edge.
  task automatic clk_step();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    address = a; data_in = d; mem_wrt = 1'b1;
    clk_step();
    mem_wrt = 1'b0;
  endtask

  task automatic rd_at(input logic [11:0] a);
    address = a; mem_wrt = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) clk_step();
    rst = 1'b0;
    #2;
    total++; if (leds !== 16'h0000) begin bad++; $display("FAIL reset_leds got=%h want=0000", leds); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", timer_irq); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_txvalid got=%b want=0", tx_valid); end
    rd_at(12'hF03);
    total++; if (data_out !== 16'hFFFF) begin bad++; $display("FAIL reset_tcmp got=%h want=ffff", data_out); end
    rd_at(12'hF05);
    total++; if (data_out !== 16'h0001) begin bad++; $display("FAIL reset_txstat got=%h want=0001", data_out); end
  endtask

  task automatic test_ram();
    wr(12'h010, 16'h1234);
    rd_at(12'h010);
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL ram_read got=%h want=1234", data_out); end
    address = 12'h010; data_in = 16'h5555; mem_wrt = 1'b1; #2;
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL ram_rdw_old got=%h want=1234", data_out); end
    clk_step(); mem_wrt = 1'b0;
    rd_at(12'h010);
    total++; if (data_out !== 16'h5555) begin bad++; $display("FAIL ram_rdw_new got=%h want=5555", data_out); end
    wr(12'h010, 16'h1234);
    wr(12'hEFF, 16'hC0DE);
    rd_at(12'hEFF);
    total++; if (data_out !== 16'hC0DE) begin bad++; $display("FAIL ram_top got=%h want=c0de", data_out); end
    wr(12'hF80, 16'hFFFF);
    rd_at(12'hF80);
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL io_hole got=%h want=0000", data_out); end
    wr(12'hF06, 16'hFFFF);
    rd_at(12'hF06);
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL io_f06 got=%h want=0000", data_out); end
  endtask

  task automatic test_led_reset();
    wr(12'hF00, 16'hA5A5);
    #2;
    total++; if (leds !== 16'hA5A5) begin bad++; $display("FAIL led_write got=%h want=a5a5", leds); end
    rst = 1'b1; address = 12'h020; data_in = 16'hBEEF; mem_wrt = 1'b1;
    clk_step();
    address = 12'hF00; data_in = 16'h7777;
    clk_step();
    rst = 1'b0; mem_wrt = 1'b0;
    #2;
    total++; if (leds !== 16'h0000) begin bad++; $display("FAIL led_after_rst got=%h want=0000", leds); end
    rd_at(12'h010);
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL ram_kept got=%h want=1234", data_out); end
    rd_at(12'h020);
    total++; if (data_out !== 16'hBEEF) begin bad++; $display("FAIL ram_wr_in_rst got=%h want=beef", data_out); end
  endtask

  task automatic test_timer_autoclr();
    logic [15:0] seq [5];
    seq[0] = 16'd0; seq[1] = 16'd1; seq[2] = 16'd2; seq[3] = 16'd3; seq[4] = 16'd0;
    wr(12'hF03, 16'h0003);
    wr(12'hF01, 16'h0000);
    wr(12'hF02, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      rd_at(12'hF01);
      total++; if (data_out !== seq[i]) begin bad++; $display("FAIL autoclr_count[%0d] got=%h want=%h", i, data_out, seq[i]); end
      total++; if (timer_irq !== 1'(i == 4)) begin bad++; $display("FAIL autoclr_irq[%0d] got=%b want=%b", i, timer_irq, i == 4); end
      clk_step();
    end
    wr(12'hF02, 16'h8003);
    #2;
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL match_w1c got=%b want=0", timer_irq); end
    rd_at(12'hF01);
    total++; if (data_out !== 16'h0002) begin bad++; $display("FAIL still_running got=%h want=0002", data_out); end
    rd_at(12'hF02);
    total++; if (data_out !== 16'h0003) begin bad++; $display("FAIL tctrl_read got=%h want=0003", data_out); end
    wr(12'hF02, 16'h0000);
  endtask

  task automatic test_timer_wrap();
    logic [15:0] seq [3];
    seq[0] = 16'hFFFE; seq[1] = 16'hFFFF; seq[2] = 16'h0000;
    wr(12'hF03, 16'h0005);
    wr(12'hF01, 16'hFFFE);
    wr(12'hF02, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      rd_at(12'hF01);
      total++; if (data_out !== seq[i]) begin bad++; $display("FAIL wrap_count[%0d] got=%h want=%h", i, data_out, seq[i]); end
      total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL wrap_irq[%0d] got=%b want=0", i, timer_irq); end
      clk_step();
    end
    // Match and W1C on the same edge: the set must win.
    wr(12'hF03, 16'h0010);
    wr(12'hF01, 16'h000F);
    clk_step();
    rd_at(12'hF01);
    total++; if (data_out !== 16'h0010) begin bad++; $display("FAIL setwin_pre got=%h want=0010", data_out); end
    wr(12'hF02, 16'h8001);
    #2;
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL setwin_irq got=%b want=1", timer_irq); end
    wr(12'hF02, 16'h8000);
    #2;
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL setwin_clear got=%b want=0", timer_irq); end
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(12'hF04, 16'(i));
    rd_at(12'hF05);
    total++; if (data_out !== 16'h0042) begin bad++; $display("FAIL fifo_full_stat got=%h want=0042", data_out); end
    wr(12'hF04, 16'h0009);
    rd_at(12'hF05);
    total++; if (data_out !== 16'h0046) begin bad++; $display("FAIL fifo_ovf_stat got=%h want=0046", data_out); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #0;
      total++; if (tx_valid !== 1'b1 || tx_data !== 16'(i)) begin
        bad++; $display("FAIL drain[%0d] got=%h/%b want=%h/1", i, tx_data, tx_valid, 16'(i)); end
      clk_step(); #2;
    end
    rd_at(12'hF05);
    total++; if (data_out !== 16'h0005) begin bad++; $display("FAIL drained_stat got=%h want=0005", data_out); end
    wr(12'hF05, 16'h0004);
    rd_at(12'hF05);
    total++; if (data_out !== 16'h0001) begin bad++; $display("FAIL ovf_clear got=%h want=0001", data_out); end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [8];
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(12'hF04, 16'h0010 + 16'(i));
    for (int i = 0; i < 7; i++) seq[i] = 16'h0011 + 16'(i);
    seq[7] = 16'h00AA;
    address = 12'hF04; data_in = 16'h00AA; mem_wrt = 1'b1; tx_ready = 1'b1;
    #2;
    total++; if (tx_data !== 16'h0010) begin bad++; $display("FAIL pushpop_head got=%h want=0010", tx_data); end
    clk_step();
    rd_at(12'hF05);
    total++; if (data_out !== 16'h0042) begin bad++; $display("FAIL pushpop_stat got=%h want=0042", data_out); end
    for (int i = 0; i < 8; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== seq[i]) begin
        bad++; $display("FAIL pushpop_drain[%0d] got=%h/%b want=%h/1", i, tx_data, tx_valid, seq[i]); end
      clk_step(); #2;
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL pushpop_empty got=%b want=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] pool [16];
    logic [11:0] a;
    logic [15:0] want;
    pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h7A3; pool[3] = 12'hEFF;
    for (int i = 0; i < 8; i++) pool[4 + i] = 12'hF00 + 12'(i);
    pool[12] = 12'hF04; pool[13] = 12'hF01; pool[14] = 12'hF80; pool[15] = 12'hFFF;
    for (int i = 0; i < 4; i++) wr(pool[i], 16'($urandom));
    for (int c = 0; c < 600; c++) begin
      a        = pool[$urandom_range(0, 15)];
      address  = a;
      mem_wrt  = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 2) == 0);
      rst      = 1'($urandom_range(0, 79) == 0);
      if (a == 12'hF01 || a == 12'hF03) data_in = 16'($urandom_range(0, 7));
      else data_in = 16'($urandom);
      #2;
      want = m_read(a);
      total++; if (data_out !== want) begin bad++; $display("FAIL rnd_read[%0d] a=%h got=%h want=%h", c, a, data_out, want); end
      total++; if (leds !== m_led) begin bad++; $display("FAIL rnd_leds[%0d] got=%h want=%h", c, leds, m_led); end
      total++; if (timer_irq !== m_match) begin bad++; $display("FAIL rnd_irq[%0d] got=%b want=%b", c, timer_irq, m_match); end
      total++; if (tx_valid !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, tx_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        total++; if (tx_data !== m_q[0]) begin bad++; $display("FAIL rnd_txdata[%0d] got=%h want=%h", c, tx_data, m_q[0]); end
      end
      clk_step();
    end
    rst = 1'b0; mem_wrt = 1'b0; tx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_wrt = 1'b0; tx_ready = 1'b0; address = '0; data_in = '0;
    test_reset();
    test_ram();
    test_led_reset();
    test_timer_autoclr();
    test_timer_wrap();
    test_fifo_overflow();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
